parking_occupancy_counter: RTL and testbench

- Upstream feeder of the per-digit 7-segment decoders in the parking-lot simulation.
- Watches two gate photo-sensors and decodes the sensor sequences into car-enter and car-exit events.
- Keeps a saturating occupancy count, presented as two BCD digits, one per HEX decoder.
- Also outputs full, empty and single-cycle event pulses for the LED and status logic.

---
 rtl/parking_occupancy_counter.sv | 208 ++++++++++++++++++++
 tb/tb_parking_occupancy_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_occupancy_counter.sv
// Parking-lot gate monitor: decodes two photo-sensor sequences into car
// enter/exit events and keeps a saturating two-digit BCD occupancy count
// for the HEX decoders, with registered full/empty flags and event pulses.
module parking_occupancy_counter #(
    parameter int unsigned CAPACITY = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic [3:0] count_ones,
    output logic [3:0] count_tens,
    output logic       full,
    output logic       empty,
    output logic       enter_pulse,
    output logic       exit_pulse
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned PAIR_W  = 2;

    localparam logic [DIGIT_W-1:0] CAP_ONES  = DIGIT_W'(CAPACITY % 10);
    localparam logic [DIGIT_W-1:0] CAP_TENS  = DIGIT_W'(CAPACITY / 10);
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] DIGIT_ONE = DIGIT_W'(1);
    localparam logic [DIGIT_W-1:0] DIGIT_ZERO = DIGIT_W'(0);

    // Sensor pair encodings as seen after synchronization: {a, b}.
    localparam logic [PAIR_W-1:0] AB_NONE  = 2'b00;
    localparam logic [PAIR_W-1:0] AB_INNER = 2'b01;
    localparam logic [PAIR_W-1:0] AB_OUTER = 2'b10;
    localparam logic [PAIR_W-1:0] AB_BOTH  = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENT1     = 3'd1,
        ENT2     = 3'd2,
        ENT3     = 3'd3,
        EXT1     = 3'd4,
        EXT2     = 3'd5,
        EXT3     = 3'd6,
        WAIT_CLR = 3'd7
    } state_t;

    state_t state;
    state_t state_nxt;

    logic a_meta;
    logic a_sync;
    logic b_meta;
    logic b_sync;
    logic [PAIR_W-1:0] ab_c;

    logic enter_ev_c;
    logic exit_ev_c;
    logic at_cap_c;
    logic at_zero_c;
    logic [DIGIT_W-1:0] ones_nxt_c;
    logic [DIGIT_W-1:0] tens_nxt_c;

    // Two-flop synchronizers for the asynchronous gate sensors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_meta <= 1'b0;
            a_sync <= 1'b0;
            b_meta <= 1'b0;
            b_sync <= 1'b0;
        end else begin
            a_meta <= sensor_a;
            a_sync <= a_meta;
            b_meta <= sensor_b;
            b_sync <= b_meta;
        end
    end

    assign ab_c = {a_sync, b_sync};

    // Gate sequence state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode of the synchronized sensor pair.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                case (ab_c)
                    AB_OUTER: state_nxt = ENT1;
                    AB_INNER: state_nxt = EXT1;
                    AB_BOTH:  state_nxt = WAIT_CLR;
                    AB_NONE:  state_nxt = IDLE;
                endcase
            end
            ENT1: begin
                case (ab_c)
                    AB_OUTER: state_nxt = ENT1;
                    AB_BOTH:  state_nxt = ENT2;
                    AB_NONE:  state_nxt = IDLE;
                    AB_INNER: state_nxt = WAIT_CLR;
                endcase
            end
            ENT2: begin
                case (ab_c)
                    AB_BOTH:  state_nxt = ENT2;
                    AB_INNER: state_nxt = ENT3;
                    AB_OUTER: state_nxt = ENT1;
                    AB_NONE:  state_nxt = WAIT_CLR;
                endcase
            end
            ENT3: begin
                case (ab_c)
                    AB_INNER: state_nxt = ENT3;
                    AB_NONE:  state_nxt = IDLE;
                    AB_BOTH:  state_nxt = ENT2;
                    AB_OUTER: state_nxt = WAIT_CLR;
                endcase
            end
            EXT1: begin
                case (ab_c)
                    AB_INNER: state_nxt = EXT1;
                    AB_BOTH:  state_nxt = EXT2;
                    AB_NONE:  state_nxt = IDLE;
                    AB_OUTER: state_nxt = WAIT_CLR;
                endcase
            end
            EXT2: begin
                case (ab_c)
                    AB_BOTH:  state_nxt = EXT2;
                    AB_OUTER: state_nxt = EXT3;
                    AB_INNER: state_nxt = EXT1;
                    AB_NONE:  state_nxt = WAIT_CLR;
                endcase
            end
            EXT3: begin
                case (ab_c)
                    AB_OUTER: state_nxt = EXT3;
                    AB_NONE:  state_nxt = IDLE;
                    AB_BOTH:  state_nxt = EXT2;
                    AB_INNER: state_nxt = WAIT_CLR;
                endcase
            end
            WAIT_CLR: begin
                if (ab_c == AB_NONE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Event decode: a car completes only when the last beam clears from stage 3.
    always_comb begin
        enter_ev_c = 1'b0;
        exit_ev_c  = 1'b0;
        if (ab_c == AB_NONE) begin
            enter_ev_c = (state == ENT3);
            exit_ev_c  = (state == EXT3);
        end
    end

    // Saturating BCD count update; digits are stepped directly in BCD.
    always_comb begin
        ones_nxt_c = count_ones;
        tens_nxt_c = count_tens;
        at_cap_c   = (count_tens == CAP_TENS) && (count_ones == CAP_ONES);
        at_zero_c  = (count_tens == DIGIT_ZERO) && (count_ones == DIGIT_ZERO);
        if (enter_ev_c && !at_cap_c) begin
            if (count_ones == DIGIT_MAX) begin
                ones_nxt_c = DIGIT_ZERO;
                tens_nxt_c = count_tens + DIGIT_ONE;
            end else begin
                ones_nxt_c = count_ones + DIGIT_ONE;
            end
        end else if (exit_ev_c && !at_zero_c) begin
            if (count_ones == DIGIT_ZERO) begin
                ones_nxt_c = DIGIT_MAX;
                tens_nxt_c = count_tens - DIGIT_ONE;
            end else begin
                ones_nxt_c = count_ones - DIGIT_ONE;
            end
        end
    end

    // Registered count, status flags and event pulses, all on the event edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_ones  <= DIGIT_ZERO;
            count_tens  <= DIGIT_ZERO;
            full        <= 1'b0;
            empty       <= 1'b1;
            enter_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
        end else begin
            count_ones  <= ones_nxt_c;
            count_tens  <= tens_nxt_c;
            full        <= (tens_nxt_c == CAP_TENS) && (ones_nxt_c == CAP_ONES);
            empty       <= (tens_nxt_c == DIGIT_ZERO) && (ones_nxt_c == DIGIT_ZERO);
            enter_pulse <= enter_ev_c;
            exit_pulse  <= exit_ev_c;
        end
    end

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Directed bench for parking_occupancy_counter with CAPACITY = 25.
module tb_parking_occupancy_counter;

    logic       clk;
    logic       reset_n;
    logic       sensor_a;
    logic       sensor_b;
    logic [3:0] count_ones;
    logic [3:0] count_tens;
    logic       full;
    logic       empty;
    logic       enter_pulse;
    logic       exit_pulse;

    int n_asserts;
    int n_fails;
    int n_enter;
    int n_exit;
    int base_enter;
    int base_exit;

    parking_occupancy_counter #(.CAPACITY(25)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sensor_a    (sensor_a),
        .sensor_b    (sensor_b),
        .count_ones  (count_ones),
        .count_tens  (count_tens),
        .full        (full),
        .empty       (empty),
        .enter_pulse (enter_pulse),
        .exit_pulse  (exit_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally, sampled away from the rising edge.
    always @(negedge clk) begin
        if (enter_pulse === 1'b1) n_enter = n_enter + 1;
        if (exit_pulse === 1'b1)  n_exit  = n_exit + 1;
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_asserts = n_asserts + 1;
        assert (obs === expv) else begin
            n_fails = n_fails + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        sensor_a = a;
        sensor_b = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic car_enter();
        hold(1'b1, 1'b0, 5);
        hold(1'b1, 1'b1, 5);
        hold(1'b0, 1'b1, 5);
        hold(1'b0, 1'b0, 5);
    endtask

    task automatic car_exit();
        hold(1'b0, 1'b1, 5);
        hold(1'b1, 1'b1, 5);
        hold(1'b1, 1'b0, 5);
        hold(1'b0, 1'b0, 5);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic int cnt();
        return int'({count_tens, count_ones});
    endfunction

    initial begin
        n_asserts = 0;
        n_fails   = 0;
        n_enter   = 0;
        n_exit    = 0;
        reset_n   = 1'b0;
        sensor_a  = 1'b0;
        sensor_b  = 1'b0;

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        check("rst_count", cnt(), 'h00);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_pulses", int'({enter_pulse, exit_pulse}), 0);
        reset_n = 1'b1;

        // Idle 10 cycles
        repeat (10) @(negedge clk);
        check("idle_count", cnt(), 'h00);
        check("idle_empty", int'(empty), 1);
        check("idle_full", int'(full), 0);
        check("idle_no_pulse", n_enter + n_exit, 0);

        // First entry with exact pulse latency after the final 00
        hold(1'b1, 1'b0, 5);
        hold(1'b1, 1'b1, 5);
        hold(1'b0, 1'b1, 5);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        @(posedge clk); #1;
        check("lat_edge1_pulse", int'(enter_pulse), 0);
        @(posedge clk); #1;
        check("lat_edge2_pulse", int'(enter_pulse), 0);
        check("lat_edge2_count", cnt(), 'h00);
        @(posedge clk); #1;
        check("lat_edge3_pulse", int'(enter_pulse), 1);
        check("lat_edge3_count", cnt(), 'h01);
        check("lat_edge3_empty", int'(empty), 0);
        @(posedge clk); #1;
        check("lat_edge4_pulse", int'(enter_pulse), 0);
        repeat (3) @(negedge clk);
        check("entry1_pulses", n_enter, 1);
        check("entry1_no_exit", n_exit, 0);

        // Entry abort: car backs out
        hold(1'b1, 1'b0, 5);
        hold(1'b1, 1'b1, 5);
        hold(1'b1, 1'b0, 5);
        hold(1'b0, 1'b0, 5);
        check("abort_count", cnt(), 'h01);
        check("abort_no_pulse", n_enter + n_exit, 1);

        // BCD wrap
        do_reset();
        base_enter = n_enter;
        base_exit  = n_exit;
        for (int i = 0; i < 9; i++) car_enter();
        check("wrap_9", cnt(), 'h09);
        car_enter();
        check("wrap_10", cnt(), 'h10);
        check("wrap_enter_pulses", n_enter - base_enter, 10);
        car_exit();
        check("wrap_exit_9", cnt(), 'h09);
        check("wrap_exit_pulses", n_exit - base_exit, 1);

        // Exit while empty saturates at zero
        do_reset();
        base_exit = n_exit;
        car_exit();
        check("empty_exit_count", cnt(), 'h00);
        check("empty_exit_flag", int'(empty), 1);
        check("empty_exit_pulse", n_exit - base_exit, 1);

        // Saturation at capacity
        do_reset();
        base_enter = n_enter;
        for (int i = 0; i < 25; i++) car_enter();
        check("sat25_count", cnt(), 'h25);
        check("sat25_full", int'(full), 1);
        car_enter();
        check("sat26_count", cnt(), 'h25);
        check("sat26_full", int'(full), 1);
        check("sat26_pulses", n_enter - base_enter, 26);
        car_exit();
        check("sat_exit_count", cnt(), 'h24);
        check("sat_exit_full", int'(full), 0);

        // Illegal pattern: both beams from idle, then inner, then clear
        base_enter = n_enter;
        base_exit  = n_exit;
        hold(1'b1, 1'b1, 5);
        hold(1'b0, 1'b1, 5);
        hold(1'b0, 1'b0, 5);
        check("illegal_count", cnt(), 'h24);
        check("illegal_no_pulse", (n_enter - base_enter) + (n_exit - base_exit), 0);

        // Asynchronous reset while in ENT2
        hold(1'b1, 1'b0, 5);
        hold(1'b1, 1'b1, 4);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_count", cnt(), 'h00);
        check("async_rst_empty", int'(empty), 1);
        check("async_rst_full", int'(full), 0);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        @(negedge clk);
        base_enter = n_enter;
        base_exit  = n_exit;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_no_pulse", (n_enter - base_enter) + (n_exit - base_exit), 0);
        check("post_rst_count", cnt(), 'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
